// File: rtl/joy_socd_resolver.sv
// joy_socd_resolver: per-player joystick sync, debounce and SOCD resolution
// Ports: clk (clk_sys); reset_n sync active-low; mode 0 last-wins / 1 neutral /
// 2 first-wins / 3 4-way; dir_in raw {U,D,L,R} per player; dir_out resolved
// registered {U,D,L,R} per player; changed one-cycle pulse per player nibble change.
module joy_socd_resolver #(
    parameter int PLAYERS  = 2,
    parameter int DEBOUNCE = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             mode,
    input  logic [4*PLAYERS-1:0]   dir_in,
    output logic [4*PLAYERS-1:0]   dir_out,
    output logic [PLAYERS-1:0]     changed
);
    localparam logic [1:0] M_NEUTRAL = 2'd1;
    localparam logic [1:0] M_FIRST   = 2'd2;
    localparam logic [1:0] M_4WAY    = 2'd3;

    // Both-new clears to none; a locked axis (first-wins with a bit already held) keeps its owner.
    function automatic logic [1:0] upd(input logic [1:0] n, input logic [1:0] cur, input logic lock);
        upd = (n == 2'b11) ? 2'b00 : lock ? cur : (n == 2'b01 || n == 2'b10) ? n : cur;
    endfunction

    for (genvar p = 0; p < PLAYERS; p++) begin : g_pl
        logic [3:0] s1, s2, deb, prev, nw, out_nxt, dout;
        logic [1:0] last_h, last_v, last_h_nxt, last_v_nxt, h, v;
        logic       last_axis, last_axis_nxt, chg;

        if (DEBOUNCE == 0) begin : g_nodeb
            assign deb = s2;
        end else begin : g_deb
            localparam int CW = $clog2(DEBOUNCE + 1);
            localparam logic [CW-1:0] LIM = CW'(DEBOUNCE - 1);
            for (genvar b = 0; b < 4; b++) begin : g_bit
                logic [CW-1:0] cnt;
                logic          d;
                always_ff @(posedge clk) begin
                    if (!reset_n) begin
                        cnt <= '0;
                        d   <= 1'b0;
                    end else if (s2[b] != d) begin
                        cnt <= (cnt == LIM) ? '0 : cnt + 1'b1;
                        d   <= (cnt == LIM) ? s2[b] : d;
                    end else begin
                        cnt <= '0;
                    end
                end
                assign deb[b] = d;
            end
        end

        always_comb begin
            nw = deb & ~prev;
            last_h_nxt = upd(nw[1:0], last_h, mode == M_FIRST && |prev[1:0]);
            last_v_nxt = upd(nw[3:2], last_v, mode == M_FIRST && |prev[3:2]);
            // A new bit on both axes at once leaves the axis priority unchanged.
            last_axis_nxt = (|nw[3:2] && !(|nw[1:0])) ? 1'b1 :
                            (|nw[1:0] && !(|nw[3:2])) ? 1'b0 : last_axis;
            h = (deb[1:0] != 2'b11) ? deb[1:0] : (mode == M_NEUTRAL) ? 2'b00 : last_h_nxt;
            v = (deb[3:2] != 2'b11) ? deb[3:2] : (mode == M_NEUTRAL) ? 2'b00 : last_v_nxt;
            out_nxt = (mode == M_4WAY && |h && |v) ? (last_axis_nxt ? {v, 2'b00} : {2'b00, h}) : {v, h};
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                s1        <= '0;
                s2        <= '0;
                prev      <= '0;
                last_h    <= '0;
                last_v    <= '0;
                last_axis <= 1'b0;
                dout      <= '0;
                chg       <= 1'b0;
            end else begin
                s1        <= dir_in[4*p +: 4];
                s2        <= s1;
                prev      <= deb;
                last_h    <= last_h_nxt;
                last_v    <= last_v_nxt;
                last_axis <= last_axis_nxt;
                dout      <= out_nxt;
                chg       <= (out_nxt != dout);
            end
        end

        assign dir_out[4*p +: 4] = dout;
        assign changed[p]        = chg;
    end
endmodule
